// File: rtl/mul_pkg.sv
// Shared encodings for the sequential Booth multiplier: FSM states and Booth step opcodes.
package mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // {Q[0], q_m1}: 01 adds M, 10 subtracts M, 00/11 leave A alone.
  function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then arithmetic
// right shift of {A, Q, q_m1}. Purely combinational.
module booth_step
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] i_a,
  input  logic [WIDTH:0]   i_q,
  input  logic             i_q_m1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH+1:0] o_a,
  output logic [WIDTH:0]   o_q,
  output logic             o_q_m1
);

  logic [WIDTH+1:0] w_m_ext;
  logic [WIDTH+1:0] w_sum;
  booth_op_t        w_op;

  always_comb begin
    w_m_ext = {i_m[WIDTH], i_m};
    w_op    = booth_decode(i_q[0], i_q_m1);
    case (w_op)
      BOOTH_ADD: w_sum = i_a + w_m_ext;
      BOOTH_SUB: w_sum = i_a - w_m_ext;
      default:   w_sum = i_a;
    endcase
  end

  assign o_a    = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
  assign o_q    = {w_sum[0], i_q[WIDTH:1]};
  assign o_q_m1 = i_q[0];

endmodule

// File: rtl/seq_booth_multiplier.sv
// Multi-cycle radix-2 Booth multiplier, signed or unsigned per transaction, with
// valid/ready handshakes on both operand and product sides.
module seq_booth_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               tc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] o,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

  state_t             r_state;
  logic [WIDTH+1:0]   r_a;
  logic [WIDTH:0]     r_q;
  logic               r_q_m1;
  logic [WIDTH:0]     r_m;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_o;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [WIDTH+1:0]   w_a;
  logic [WIDTH:0]     w_q;
  logic               w_q_m1;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a    (r_a),
    .i_q    (r_q),
    .i_q_m1 (r_q_m1),
    .i_m    (r_m),
    .o_a    (w_a),
    .o_q    (w_q),
    .o_q_m1 (w_q_m1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_q         <= '0;
      r_q_m1      <= 1'b0;
      r_m         <= '0;
      r_cnt       <= '0;
      r_o         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // One extra bit lets unsigned operands be treated as non-negative signed.
            r_m        <= {tc & a[WIDTH-1], a};
            r_q        <= {tc & b[WIDTH-1], b};
            r_a        <= '0;
            r_q_m1     <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_CALC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_CALC: begin
          r_a    <= w_a;
          r_q    <= w_q;
          r_q_m1 <= w_q_m1;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LastCnt) begin
            r_o         <= {w_a[WIDTH-2:0], w_q};
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign o         = r_o;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed checks of the Booth multiplier at WIDTH=4 and WIDTH=8, plus a short
// model-checked random run with output stalls at WIDTH=8.
module tb_seq_booth_multiplier;

  logic clk;
  logic rst_n;

  logic       v4, r4, tc4, ov4, or4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] o4;

  logic        v8, r8, tc8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] o8;

  int n_chk = 0;
  int n_err = 0;

  seq_booth_multiplier #(
    .WIDTH (4)
  ) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v4),
    .in_ready  (r4),
    .a         (a4),
    .b         (b4),
    .tc        (tc4),
    .out_valid (ov4),
    .out_ready (or4),
    .o         (o4),
    .busy      (busy4)
  );

  seq_booth_multiplier #(
    .WIDTH (8)
  ) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v8),
    .in_ready  (r8),
    .a         (a8),
    .b         (b8),
    .tc        (tc8),
    .out_valid (ov8),
    .out_ready (or8),
    .o         (o8),
    .busy      (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edge count includes the accepting edge; out_valid is expected after WIDTH+2 edges.
  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic ttc,
                      input logic [7:0] exp, input string tag);
    int n;
    @(negedge clk);
    a4 = ta; b4 = tb; tc4 = ttc; or4 = 1'b1;
    n = 0;
    while (!r4 && n < 20) begin @(negedge clk); n++; end
    v4 = 1'b1;
    @(posedge clk);
    n = 1;
    #1 v4 = 1'b0;
    while (!ov4 && n < 20) begin @(posedge clk); n++; #1; end
    check({tag, " latency"}, 32'(n), 32'd6);
    check({tag, " o"}, 32'(o4), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic ttc,
                      input logic [15:0] exp, input int stall, input string tag);
    int n;
    @(negedge clk);
    a8 = ta; b8 = tb; tc8 = ttc; or8 = (stall == 0);
    n = 0;
    while (!r8 && n < 30) begin @(negedge clk); n++; end
    v8 = 1'b1;
    @(posedge clk);
    n = 1;
    #1 v8 = 1'b0;
    while (!ov8 && n < 30) begin @(posedge clk); n++; #1; end
    check({tag, " latency"}, 32'(n), 32'd10);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk); a8 = ~a8; v8 = 1'b1;
        @(posedge clk); #1;
      end
      @(negedge clk); v8 = 1'b0; or8 = 1'b1;
      check({tag, " stall valid"}, 32'(ov8), 32'd1);
    end
    check({tag, " o"}, 32'(o8), 32'(exp));
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] model8(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mtc);
    int x, y;
    if (mtc) begin
      x = int'($signed(ma));
      y = int'($signed(mb));
    end else begin
      x = int'(ma);
      y = int'(mb);
    end
    return 16'(x * y);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] held;
    logic [7:0] ra, rb;
    logic       rtc;
    rst_n = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; tc4 = 1'b0; or4 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; tc8 = 1'b0; or8 = 1'b0;
    #12;
    check("reset in_ready", 32'(r4), 32'd1);
    check("reset out_valid", 32'(ov4), 32'd0);
    check("reset busy", 32'(busy4), 32'd0);
    check("reset o4", 32'(o4), 32'd0);
    check("reset o8", 32'(o8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run4(4'hD, 4'h2, 1'b1, 8'hFA, "s -3*2");
    run4(4'h7, 4'h8, 1'b1, 8'hC8, "s 7*-8");
    run4(4'h8, 4'h8, 1'b1, 8'h40, "s -8*-8");
    run4(4'hF, 4'hF, 1'b0, 8'hE1, "u 15*15");
    run4(4'hF, 4'hF, 1'b1, 8'h01, "s -1*-1");
    run4(4'h0, 4'hB, 1'b1, 8'h00, "s 0*-5");
    run4(4'h9, 4'h0, 1'b0, 8'h00, "u 9*0");

    // Backpressure: product held, toggled inputs ignored.
    @(negedge clk);
    a4 = 4'h6; b4 = 4'h5; tc4 = 1'b0; or4 = 1'b0; v4 = 1'b1;
    @(posedge clk);
    #1 v4 = 1'b0;
    for (int i = 0; i < 12 && !ov4; i++) begin @(posedge clk); #1; end
    check("bp first o", 32'(o4), 32'h1E);
    held = o4;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); a4 = ~a4; b4 = b4 + 4'd3; v4 = ~v4;
      @(posedge clk); #1;
      check("bp o stable", 32'(o4), 32'(held));
    end
    check("bp in_ready", 32'(r4), 32'd0);
    check("bp out_valid", 32'(ov4), 32'd1);
    check("bp busy", 32'(busy4), 32'd1);
    @(negedge clk); v4 = 1'b0; or4 = 1'b1;
    @(posedge clk); #1;
    check("release in_ready", 32'(r4), 32'd1);
    check("release out_valid", 32'(ov4), 32'd0);
    check("release busy", 32'(busy4), 32'd0);

    // Reset three cycles into CALC discards the in-flight product.
    @(negedge clk);
    a4 = 4'h3; b4 = 4'h3; tc4 = 1'b0; v4 = 1'b1;
    @(posedge clk);
    #1 v4 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(ov4), 32'd0);
    check("midrst in_ready", 32'(r4), 32'd1);
    check("midrst o", 32'(o4), 32'd0);
    check("midrst busy", 32'(busy4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run4(4'hB, 4'hA, 1'b1, 8'h1E, "s -5*-6");

    run8(8'h80, 8'h80, 1'b1, 16'h4000, 0, "s8 -128*-128");
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 2, "u8 255*255");
    run8(8'h7F, 8'h80, 1'b1, 16'hC080, 0, "s8 127*-128");
    run8(8'h80, 8'h02, 1'b0, 16'h0100, 3, "u8 128*2");
    run8(8'h00, 8'hFF, 1'b1, 16'h0000, 0, "s8 0*-1");
    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rtc = 1'($urandom_range(0, 1));
      run8(ra, rb, rtc, model8(ra, rb, rtc), int'($urandom_range(0, 3)), "rnd8");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
